// File: rtl/cdc_push_framer.sv
// A-domain framing stage ahead of the A->B CDC FIFO: buffers one message,
// then pushes a {seq, trunc, len} header followed by the payload words.
module cdc_push_framer #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned MaxWords  = 16,
  parameter int unsigned SeqWidth  = 8
) (
  input  logic                 clk_DA,
  input  logic                 rst,
  input  logic                 InValid_DA,
  input  logic [DataWidth-1:0] InData_DA,
  input  logic                 InLast_DA,
  output logic                 InReady_DA,
  input  logic                 FifoFull_DA,
  output logic                 Push_DA,
  output logic [DataWidth-1:0] FifoData_DA,
  output logic                 Busy_DA,
  output logic                 TruncSticky_DA
);

  localparam int unsigned LenWidth = $clog2(MaxWords + 1);
  localparam int unsigned IdxWidth = (MaxWords > 1) ? $clog2(MaxWords) : 1;
  localparam logic [LenWidth-1:0] MaxLen = LenWidth'(MaxWords);

  localparam logic [1:0] StFill    = 2'd0;
  localparam logic [1:0] StHeader  = 2'd1;
  localparam logic [1:0] StPayload = 2'd2;

  if (MaxWords < 1) begin : g_bad_depth
    $error("cdc_push_framer: MaxWords must be at least 1");
  end
  if (DataWidth < SeqWidth + 1 + LenWidth) begin : g_bad_width
    $error("cdc_push_framer: DataWidth too small for seq, trunc and len fields");
  end

  logic [1:0]           state_q, state_d;
  logic [LenWidth-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LenWidth-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic                 trunc_q, trunc_d;
  logic [SeqWidth-1:0]  seq_q, seq_d;
  logic                 sticky_q, sticky_d;
  logic                 mem_we;
  logic [DataWidth-1:0] mem [MaxWords];

  // Handshake outputs depend only on state and FIFO full, never on InValid_DA.
  assign InReady_DA     = (state_q == StFill);
  assign Busy_DA        = (state_q != StFill);
  assign Push_DA        = (state_q != StFill) && !FifoFull_DA;
  assign TruncSticky_DA = sticky_q;

  always_ff @(posedge clk_DA or posedge rst) begin
    if (rst) begin
      state_q  <= StFill;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      len_q    <= '0;
      trunc_q  <= 1'b0;
      seq_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      len_q    <= len_d;
      trunc_q  <= trunc_d;
      seq_q    <= seq_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    len_d    = len_q;
    trunc_d  = trunc_q;
    seq_d    = seq_q;
    sticky_d = sticky_q;
    mem_we   = 1'b0;
    case (state_q)
      StFill: begin
        if (InValid_DA) begin
          // Beats past the buffer depth are dropped and mark the frame truncated.
          if (wr_cnt_q < MaxLen) begin
            mem_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + LenWidth'(1);
          end else begin
            trunc_d = 1'b1;
          end
          if (InLast_DA) begin
            len_d    = wr_cnt_d;
            sticky_d = sticky_q | trunc_d;
            state_d  = StHeader;
          end
        end
      end
      StHeader: begin
        if (!FifoFull_DA) begin
          rd_cnt_d = '0;
          state_d  = StPayload;
        end
      end
      StPayload: begin
        if (!FifoFull_DA) begin
          if (rd_cnt_q == len_q - LenWidth'(1)) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            trunc_d  = 1'b0;
            seq_d    = seq_q + SeqWidth'(1);
            state_d  = StFill;
          end else begin
            rd_cnt_d = rd_cnt_q + LenWidth'(1);
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  // Payload buffer; contents are only observed after being written this frame.
  always_ff @(posedge clk_DA) begin
    if (mem_we) begin
      mem[IdxWidth'(wr_cnt_q)] <= InData_DA;
    end
  end

  always_comb begin
    FifoData_DA = '0;
    case (state_q)
      StHeader: begin
        FifoData_DA[DataWidth-1 -: SeqWidth]   = seq_q;
        FifoData_DA[DataWidth-SeqWidth-1]      = trunc_q;
        FifoData_DA[LenWidth-1:0]              = len_q;
      end
      StPayload: FifoData_DA = mem[IdxWidth'(rd_cnt_q)];
      default:   FifoData_DA = '0;
    endcase
  end

endmodule

// File: tb/tb_cdc_push_framer.sv
// Scoreboard bench for cdc_push_framer: expected FIFO words are queued as
// frames are sent and compared against the words the DUT actually pushes.
module tb_cdc_push_framer;

  logic        clk_DA = 1'b0;
  logic        rst;
  logic        InValid_DA;
  logic [31:0] InData_DA;
  logic        InLast_DA;
  logic        InReady_DA;
  logic        FifoFull_DA;
  logic        Push_DA;
  logic [31:0] FifoData_DA;
  logic        Busy_DA;
  logic        TruncSticky_DA;

  int errors = 0;
  int checks = 0;
  int seq_m  = 0;
  int illegal_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  cdc_push_framer #(.DataWidth(32), .MaxWords(16), .SeqWidth(8)) dut (
    .clk_DA(clk_DA), .rst(rst),
    .InValid_DA(InValid_DA), .InData_DA(InData_DA), .InLast_DA(InLast_DA),
    .InReady_DA(InReady_DA), .FifoFull_DA(FifoFull_DA), .Push_DA(Push_DA),
    .FifoData_DA(FifoData_DA), .Busy_DA(Busy_DA), .TruncSticky_DA(TruncSticky_DA)
  );

  always #5 clk_DA = ~clk_DA;

  // Capture every word the FIFO would accept.
  always @(negedge clk_DA) begin
    if (Push_DA) got_q.push_back(FifoData_DA);
    if (Push_DA && FifoFull_DA) illegal_cnt++;
  end

  function automatic logic [31:0] hdr(input int s, input bit t, input int len);
    return (32'(s % 256) << 24) | (32'(t) << 23) | 32'(len);
  endfunction

  // Drive one message and queue the words the framer should emit for it.
  task automatic send_frame(input int n, input logic [31:0] base, input bit keep);
    int kept = (n > 16) ? 16 : n;
    exp_q.push_back(hdr(seq_m, n > 16, kept));
    for (int i = 0; i < kept; i++) exp_q.push_back(base + 32'(i));
    seq_m = (seq_m + 1) % 256;
    for (int i = 0; i < n; i++) begin
      int waited = 0;
      InValid_DA = 1'b1;
      InData_DA  = base + 32'(i);
      InLast_DA  = (i == n - 1);
      while (!InReady_DA && waited < 200) begin
        @(posedge clk_DA); #1;
        waited++;
      end
      checks++;
      if (waited >= 200) begin
        errors++;
        $display("FAIL send_timeout: InReady_DA stayed %b, want 1", InReady_DA);
      end
      @(posedge clk_DA); #1;
    end
    if (!keep) begin
      InValid_DA = 1'b0;
      InLast_DA  = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (got_q.size() < exp_q.size() && w < 3000) begin
      @(negedge clk_DA);
      w++;
    end
    repeat (3) @(negedge clk_DA);
  endtask

  task automatic test_reset();
    rst = 1'b1; InValid_DA = 1'b0; InData_DA = '0; InLast_DA = 1'b0; FifoFull_DA = 1'b0;
    repeat (2) @(negedge clk_DA);
    checks += 5;
    if (InReady_DA !== 1'b1)     begin errors++; $display("FAIL rst_ready: got %b want 1", InReady_DA); end
    if (Push_DA !== 1'b0)        begin errors++; $display("FAIL rst_push: got %b want 0", Push_DA); end
    if (FifoData_DA !== 32'h0)   begin errors++; $display("FAIL rst_data: got %h want 0", FifoData_DA); end
    if (Busy_DA !== 1'b0)        begin errors++; $display("FAIL rst_busy: got %b want 0", Busy_DA); end
    if (TruncSticky_DA !== 1'b0) begin errors++; $display("FAIL rst_sticky: got %b want 0", TruncSticky_DA); end
    @(posedge clk_DA); #1 rst = 1'b0;
    got_q.delete();
  endtask

  task automatic test_clean_frame();
    logic [31:0] want [4];
    logic [31:0] e, g;
    want[0] = 32'h3; want[1] = 32'hA1; want[2] = 32'hA2; want[3] = 32'hA3;
    send_frame(3, 32'hA1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_DA);
      checks += 3;
      if (Push_DA !== 1'b1)      begin errors++; $display("FAIL clean_push%0d: got %b want 1", k, Push_DA); end
      if (FifoData_DA !== want[k]) begin errors++; $display("FAIL clean_data%0d: got %h want %h", k, FifoData_DA, want[k]); end
      if (InReady_DA !== 1'b0)   begin errors++; $display("FAIL clean_ready_low%0d: got %b want 0", k, InReady_DA); end
    end
    @(negedge clk_DA);
    checks += 2;
    if (InReady_DA !== 1'b1) begin errors++; $display("FAIL clean_ready_back: got %b want 1", InReady_DA); end
    if (Push_DA !== 1'b0)    begin errors++; $display("FAIL clean_push_end: got %b want 0", Push_DA); end
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL clean_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL clean_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_truncation();
    logic [31:0] e, g;
    int idx = 0;
    checks++;
    if (TruncSticky_DA !== 1'b0) begin errors++; $display("FAIL trunc_sticky_pre: got %b want 0", TruncSticky_DA); end
    send_frame(20, 32'd1, 1'b0);
    checks++;
    if (TruncSticky_DA !== 1'b1) begin errors++; $display("FAIL trunc_sticky: got %b want 1", TruncSticky_DA); end
    drain();
    checks++;
    if (got_q.size() != 17) begin errors++; $display("FAIL trunc_count: got %0d want 17", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL trunc_word%0d: got %h want %h", idx, g, e); end
      if (idx == 0) begin
        checks++;
        if (g !== 32'h01800010) begin errors++; $display("FAIL trunc_header: got %h want 01800010", g); end
      end
      idx++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] e, g;
    send_frame(3, 32'hA1, 1'b0);
    @(posedge clk_DA); #1 FifoFull_DA = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_DA);
      checks += 3;
      if (Push_DA !== 1'b0)          begin errors++; $display("FAIL bp_push%0d: got %b want 0", k, Push_DA); end
      if (FifoData_DA !== 32'hA1)    begin errors++; $display("FAIL bp_hold%0d: got %h want a1", k, FifoData_DA); end
      if (Busy_DA !== 1'b1)          begin errors++; $display("FAIL bp_busy%0d: got %b want 1", k, Busy_DA); end
      @(posedge clk_DA); #1;
    end
    FifoFull_DA = 1'b0;
    drain();
    checks += 2;
    if (got_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
    if (illegal_cnt != 0)  begin errors++; $display("FAIL bp_push_while_full: got %0d want 0", illegal_cnt); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e, g;
    send_frame(2, 32'hC1, 1'b1);
    InData_DA = 32'hD0; InLast_DA = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_DA);
      checks++;
      if (InReady_DA !== 1'b0) begin errors++; $display("FAIL hold_ready%0d: got %b want 0", k, InReady_DA); end
    end
    @(negedge clk_DA);
    checks++;
    if (InReady_DA !== 1'b1) begin errors++; $display("FAIL hold_ready_rise: got %b want 1", InReady_DA); end
    send_frame(1, 32'hD0, 1'b0);
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL hold_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL hold_word: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid_payload();
    logic [31:0] e, g;
    send_frame(5, 32'hE0, 1'b0);
    repeat (3) @(posedge clk_DA);
    #1 rst = 1'b1;
    #1;
    checks += 6;
    if (InReady_DA !== 1'b1)     begin errors++; $display("FAIL mid_rst_ready: got %b want 1", InReady_DA); end
    if (Push_DA !== 1'b0)        begin errors++; $display("FAIL mid_rst_push: got %b want 0", Push_DA); end
    if (FifoData_DA !== 32'h0)   begin errors++; $display("FAIL mid_rst_data: got %h want 0", FifoData_DA); end
    if (Busy_DA !== 1'b0)        begin errors++; $display("FAIL mid_rst_busy: got %b want 0", Busy_DA); end
    if (TruncSticky_DA !== 1'b0) begin errors++; $display("FAIL mid_rst_sticky: got %b want 0", TruncSticky_DA); end
    if (got_q.size() != 3)       begin errors++; $display("FAIL mid_rst_pushed: got %0d want 3", got_q.size()); end
    @(posedge clk_DA); #1 rst = 1'b0;
    exp_q.delete(); got_q.delete();
    seq_m = 0;
    send_frame(1, 32'hB0, 1'b0);
    drain();
    checks += 3;
    if (got_q.size() != 2) begin errors++; $display("FAIL mid_count: got %0d want 2", got_q.size()); end
    g = (got_q.size() > 0) ? got_q.pop_front() : 32'hX;
    if (g !== 32'h00000001) begin errors++; $display("FAIL mid_header: got %h want 00000001", g); end
    g = (got_q.size() > 0) ? got_q.pop_front() : 32'hX;
    if (g !== 32'hB0) begin errors++; $display("FAIL mid_payload: got %h want b0", g); end
    e = 32'h0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_seq_wrap();
    logic [31:0] e, g;
    int idx = 0;
    #1 rst = 1'b1;
    @(posedge clk_DA); #1 rst = 1'b0;
    seq_m = 0;
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 257; i++) send_frame(1, 32'(i) + 32'h100, 1'b0);
    drain();
    checks++;
    if (got_q.size() != 514) begin errors++; $display("FAIL wrap_count: got %0d want 514", got_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_word%0d: got %h want %h", idx, g, e); end
      if (idx == 512) begin
        checks++;
        if (g !== 32'h00000001) begin errors++; $display("FAIL wrap_header257: got %h want 00000001", g); end
      end
      idx++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_clean_frame();
    test_truncation();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_payload();
    test_seq_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
